// File: rtl/float_fixed_converter_if.sv
// Handshake bundle for the float-to-fixed converter.
// master drives operands and consumes results; slave is the converter.
interface float_fixed_converter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] result;
    logic        overflow;
    logic        underflow;
    logic        invalid;

    modport master (
        output in_valid, data, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, invalid
    );

    modport slave (
        input  in_valid, data, out_ready,
        output in_ready, out_valid, result, overflow, underflow, invalid
    );
endinterface

// File: rtl/float_fixed_converter.sv
// IEEE-754 single -> 22-bit sign-magnitude fixed (1 int + 20 frac); FLOAT_FIXED_ROUND_EN selects round-half-away.
// Latency: 130-exp cycles (3..24) on the shift path, 1 cycle for special cases.
// Backpressure: one operand in flight; result held in DONE until out_ready, in_ready only in IDLE.
module float_fixed_converter (
    input  logic                    clk,
    input  logic                    rst_n,
    float_fixed_converter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [23:0] work;
    logic [4:0]  cnt;
    logic        sign_q;
    logic        special;
    logic [21:0] result_q;
    logic        ovf_q, unf_q, inv_q;
    logic        out_valid_q, in_ready_q;

    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_frac;
    logic [7:0]  sh_full;
    logic [23:0] work_nxt;
    logic        guard;
    logic [21:0] mag_sum;
    logic        sat;
    logic        unused_bits;

    assign in_sign  = bus.data[31];
    assign in_exp   = bus.data[30:23];
    assign in_frac  = bus.data[22:0];
    assign sh_full  = 8'd130 - in_exp;
    assign work_nxt = {1'b0, work[23:1]};
    assign guard    = work[0];

`ifdef FLOAT_FIXED_ROUND_EN
    assign mag_sum = {1'b0, work_nxt[20:0]} + {21'd0, guard};
`else
    assign mag_sum = {1'b0, work_nxt[20:0]};
`endif
    // Only reachable with rounding: 0x1FFFFF + guard carries into bit 21.
    assign sat = mag_sum[21];

    assign unused_bits = ^{work_nxt[23:21], guard, sh_full[7:5]};

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.invalid   = inv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            work        <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            special     <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        sign_q     <= in_sign;
                        work       <= {1'b1, in_frac};
                        ovf_q      <= 1'b0;
                        unf_q      <= 1'b0;
                        inv_q      <= 1'b0;
                        special    <= 1'b1;
                        state      <= SHIFT;
                        // Special cases park their answer now and surface it one edge later.
                        if (in_exp == 8'd255 && in_frac != '0) begin
                            result_q <= '0;
                            inv_q    <= 1'b1;
                        end else if (in_exp >= 8'd128) begin
                            result_q <= {in_sign, 21'h1FFFFF};
                            ovf_q    <= 1'b1;
                        end else if (in_exp == 8'd0) begin
                            result_q <= '0;
                            unf_q    <= (in_frac != '0);
                        end else if (in_exp <= 8'd105) begin
                            result_q <= '0;
                            unf_q    <= 1'b1;
                        end else begin
                            special <= 1'b0;
                            cnt     <= sh_full[4:0];
                        end
                    end
                end
                SHIFT: begin
                    if (special) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        work <= work_nxt;
                        cnt  <= cnt - 5'd1;
                        if (cnt == 5'd1) begin
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                            if (sat) begin
                                result_q <= {sign_q, 21'h1FFFFF};
                                ovf_q    <= 1'b1;
                            end else if (mag_sum[20:0] == '0) begin
                                result_q <= '0;
                                unf_q    <= 1'b1;
                            end else begin
                                result_q <= {sign_q, mag_sum[20:0]};
                            end
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_float_fixed_converter.sv
// Scoreboard bench: randomized floats against an arithmetic reference model of the conversion.
module tb_float_fixed_converter;
`ifdef FLOAT_FIXED_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    typedef struct {
        logic [31:0] d;
        logic [21:0] r;
        logic        ov;
        logic        un;
        logic        inv;
        int          due;
        int          stall;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        int          stall;
    } stim_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    exp_t exp_q[$];
    stim_t stim_q[$];
    bit   active;
    bit   leaving;

    float_fixed_converter_if bus ();

    float_fixed_converter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Value = M * 2^(e-150); fixed magnitude = value * 2^20 = M / 2^(130-e).
    function automatic exp_t model(input logic [31:0] d, input int t0, input int stall);
        exp_t   x;
        logic   s;
        int     e;
        longint m;
        longint mag;
        int     sh;
        s = d[31];
        e = int'(d[30:23]);
        x.d = d; x.r = '0; x.ov = 1'b0; x.un = 1'b0; x.inv = 1'b0;
        x.due = t0 + 1; x.stall = stall;
        if (e == 255 && d[22:0] != 0) begin
            x.inv = 1'b1;
        end else if (e >= 128) begin
            x.ov = 1'b1;
            x.r  = {s, 21'h1FFFFF};
        end else if (e == 0) begin
            x.un = (d[22:0] != 0);
        end else begin
            m  = longint'({1'b1, d[22:0]});
            sh = 130 - e;
            if (sh >= 26)      mag = 0;
            else if (ROUND)    mag = (m + (longint'(1) << (sh - 1))) / (longint'(1) << sh);
            else               mag = m / (longint'(1) << sh);
            if (e >= 106) x.due = t0 + sh;
            if (mag >= (longint'(1) << 21)) begin
                x.ov = 1'b1;
                mag  = (longint'(1) << 21) - 1;
            end
            if (mag == 0) begin
                x.un = 1'b1;
                x.r  = '0;
            end else begin
                x.r = {s, mag[20:0]};
            end
        end
        return x;
    endfunction

    // Monitor: pops on each new out_valid, checks value, flags, latency, hold and release.
    initial begin
        int   k;
        exp_t cur;
        k = 0;
        active = 1'b0;
        leaving = 1'b0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
                leaving = 1'b0;
            end else if (leaving) begin
                check("in_ready_after_done", 64'(bus.in_ready), 64'd1);
                check("out_valid_dropped", 64'(bus.out_valid), 64'd0);
                leaving = 1'b0;
                active = 1'b0;
                bus.out_ready = 1'(($urandom_range(0, 1)));
            end else if (bus.out_valid) begin
                if (!active) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
                        k = 0;
                    end else begin
                        cur = exp_q.pop_front();
                        check($sformatf("result[%h]", cur.d), 64'(bus.result), 64'(cur.r));
                        check($sformatf("flags[%h]", cur.d),
                              64'({bus.overflow, bus.underflow, bus.invalid}),
                              64'({cur.ov, cur.un, cur.inv}));
                        check($sformatf("latency[%h]", cur.d), 64'(cyc), 64'(cur.due));
                        active = 1'b1;
                        k = cur.stall;
                    end
                end else begin
                    check("hold_result", 64'(bus.result), 64'(cur.r));
                    check("hold_flags", 64'({bus.overflow, bus.underflow, bus.invalid}),
                          64'({cur.ov, cur.un, cur.inv}));
                end
                if (k == 0) begin
                    bus.out_ready = 1'b1;
                    leaving = 1'b1;
                end else begin
                    bus.out_ready = 1'b0;
                    k = k - 1;
                end
            end else begin
                bus.out_ready = 1'(($urandom_range(0, 1)));
            end
        end
    end

    // Stimulus
    initial begin
        stim_t st;
        int    guard;
        int    e;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.data = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_flags", 64'({bus.overflow, bus.underflow, bus.invalid}), 64'd0);
        rst_n = 1'b1;

        // Abort an operation mid-shift; it must never produce a result.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.data = 32'h3F800000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("busy_after_accept", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        stim_q.push_back('{32'h3F000000, 0});
        stim_q.push_back('{32'h3F800000, 0});
        stim_q.push_back('{32'hBFC00000, 5});
        stim_q.push_back('{32'h40000000, 1});
        stim_q.push_back('{32'hFF800000, 0});
        stim_q.push_back('{32'h7FC00000, 2});
        stim_q.push_back('{32'h80000000, 0});
        stim_q.push_back('{32'h00000001, 0});
        stim_q.push_back('{32'h35000000, 0});
        stim_q.push_back('{32'h35800000, 0});
        stim_q.push_back('{32'h3FFFFFFF, 0});
        stim_q.push_back('{32'h34FFFFFF, 0});
        stim_q.push_back('{32'hBF7FFFFF, 3});
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 8) e = $urandom_range(100, 130);
            else                          e = $urandom_range(0, 255);
            st.d = {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
            st.stall = $urandom_range(0, 3);
            stim_q.push_back(st);
        end

        guard = 0;
        while (stim_q.size() > 0 && guard < 40000) begin
            @(negedge clk);
            guard++;
            if (bus.in_ready) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.in_valid = 1'b0;
                end else begin
                    st = stim_q.pop_front();
                    bus.in_valid = 1'b1;
                    bus.data = st.d;
                    exp_q.push_back(model(st.d, cyc + 1, st.stall));
                end
            end else begin
                // Junk while busy must be ignored.
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.data = $urandom;
            end
        end
        check("stimulus_timeout", 64'(stim_q.size()), 64'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;

        guard = 0;
        while ((exp_q.size() > 0 || active) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
